// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
//   DIV_W_DEF       : default width of a channel's divide ratio
//   DEFAULT_DIV_DEF : default ratio loaded into every channel at reset
//   ch_idx_w()      : width of a channel index, never less than one bit
package clk_div_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 4;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active ratio D, shadow ratio S, period counter and
// registered clk_out/tick/pending outputs.
//   clk_in    : sole clock, rising edge
//   reset     : synchronous, active-high
//   en_i      : run enable; low parks the counter at 0 and drives outputs low
//   sync_i    : restart the period at cnt 0 and adopt the shadow ratio
//   we_i      : write div_i into the shadow ratio
//   div_i     : new divide ratio
//   clk_out_o : divided clock, high for D-floor(D/2) cycles of each period
//   tick_o    : high in the output cycle that shows the last count of a period
//   pending_o : shadow ratio written but not yet active
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic [DIV_W-1:0] high_s;
  logic [DIV_W-1:0] shd_eff_s;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             stopped_s;
  logic             last_s;
  logic             load_s;

  // Next-state logic for counter, ratios, pending flag and outputs.
  always_comb begin
    stopped_s = (div_q == ZERO);
    last_s    = !stopped_s && (cnt_q == (div_q - ONE));
    high_s    = div_q - (div_q >> 1'b1);
    // A write in the same cycle as a load event is taken by that load.
    shd_eff_s = we_i ? div_i : shd_q;
    // Ratio changes only where a period starts at cnt 0, so no period is cut or stretched.
    load_s    = sync_i || stopped_s || (en_i && last_s);

    shd_d = shd_eff_s;
    if (load_s) begin
      div_d  = shd_eff_s;
      pend_d = 1'b0;
    end else begin
      div_d  = div_q;
      pend_d = we_i ? 1'b1 : pend_q;
    end

    if (!en_i || stopped_s || sync_i || last_s) begin
      cnt_d = ZERO;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // Outputs show the current count one cycle later.
    clk_d  = en_i && !stopped_s && (cnt_q < high_s);
    tick_d = en_i && last_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q  <= ZERO;
      div_q  <= RST_DIV;
      shd_q  <= RST_DIV;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
//   clk_in      : sole clock, rising edge
//   reset       : synchronous, active-high
//   en          : per-channel run enable
//   sync        : one-cycle pulse restarting all channels in phase
//   cfg_we      : ratio write strobe
//   cfg_ch      : channel index of the write; indices >= NUM_CH are ignored
//   cfg_div     : new divide ratio
//   clk_out     : divided clock per channel (registered)
//   tick        : last-cycle-of-period pulse per channel (registered)
//   cfg_pending : per-channel shadow ratio waiting for a period boundary
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               en,
  input  logic                            sync,
  input  logic                            cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]                cfg_div,
  output logic [NUM_CH-1:0]               clk_out,
  output logic [NUM_CH-1:0]               tick,
  output logic [NUM_CH-1:0]               cfg_pending
);

  logic [NUM_CH-1:0] we_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // An out-of-range index matches no channel, so the write is dropped.
    assign we_s[i] = cfg_we && (int'(cfg_ch) == i);

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .reset     (reset),
      .en_i      (en[i]),
      .sync_i    (sync),
      .we_i      (we_s[i]),
      .div_i     (cfg_div),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .pending_o (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int DEF    = 4;

  logic              clk_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int errors = 0;
  int checks = 0;

  // Reference model: per channel the active ratio, shadow ratio, pending
  // flag and position inside the current period, plus predicted outputs.
  int m_d    [NUM_CH];
  int m_s    [NUM_CH];
  bit m_pend [NUM_CH];
  int m_pos  [NUM_CH];
  bit e_clk  [NUM_CH];
  bit e_tick [NUM_CH];

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .en          (en),
    .sync        (sync),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge worth of behaviour, from the rules: a period of D cycles,
  // the first D-D/2 of them high, the last one ticking; ratio swaps only at a
  // period end, on sync, or at once when stopped.
  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit wr;
      bit period_end;
      bit run;
      int ns;
      wr = cfg_we && (int'(cfg_ch) == c);
      if (reset) begin
        m_d[c] = DEF; m_s[c] = DEF; m_pend[c] = 1'b0; m_pos[c] = 0;
        e_clk[c] = 1'b0; e_tick[c] = 1'b0;
      end else begin
        run        = en[c] && (m_d[c] > 0);
        e_clk[c]   = run && (m_pos[c] < (m_d[c] - m_d[c] / 2));
        e_tick[c]  = run && (m_pos[c] == m_d[c] - 1);
        period_end = e_tick[c];
        ns         = wr ? int'(cfg_div) : m_s[c];
        if (!run || sync || period_end) m_pos[c] = 0;
        else                            m_pos[c] = m_pos[c] + 1;
        if (sync || m_d[c] == 0 || period_end) begin
          m_d[c] = ns; m_s[c] = ns; m_pend[c] = 1'b0;
        end else if (wr) begin
          m_s[c] = ns; m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(e_clk[c]));
      chk($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(e_tick[c]));
      chk($sformatf("cfg_pending[%0d]", c), 32'(cfg_pending[c]), 32'(m_pend[c]));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr_cfg(input int ch, input int d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(d);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic check_default_pattern(input string tag);
    logic [7:0] pat_c;
    logic [7:0] pat_t;
    logic [7:0] exp_c;
    logic [7:0] exp_t;
    exp_c = 8'b1100_1100;
    exp_t = 8'b0001_0001;
    pat_c = 8'h00; pat_t = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cycle();
      pat_c = {pat_c[6:0], clk_out[0]};
      pat_t = {pat_t[6:0], tick[0]};
    end
    chk({tag, "_clk_pattern"}, 32'(pat_c), 32'(exp_c));
    chk({tag, "_tick_pattern"}, 32'(pat_t), 32'(exp_t));
  endtask

  initial begin
    reset = 1'b1; en = 4'h0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_d[c] = DEF; m_s[c] = DEF; m_pend[c] = 1'b0; m_pos[c] = 0;
      e_clk[c] = 1'b0; e_tick[c] = 1'b0;
    end

    // Reset state
    run(2);
    chk("reset_outputs", 32'({clk_out, tick, cfg_pending}), 32'd0);

    // Default ratio 4 on all channels
    reset = 1'b0; en = 4'hF;
    check_default_pattern("default");

    // Channel 2 to ratio 5, others keep running
    wr_cfg(2, 5);
    run(12);

    // Channel 1 ratio 6 written at cnt 1 of a ratio-4 period
    for (int k = 0; k < 8 && m_pos[1] != 1; k++) cycle();
    chk("ch1_phase_found", 32'(m_pos[1]), 32'd1);
    wr_cfg(1, 6);
    chk("ch1_pending_set", 32'(cfg_pending[1]), 32'd1);
    run(14);

    // Channel 0 stopped, then ratio 1
    wr_cfg(0, 0);
    run(4);
    chk("ch0_stopped", 32'({clk_out[0], tick[0]}), 32'd0);
    wr_cfg(0, 1);
    run(4);
    chk("ch0_div1", 32'({clk_out[0], tick[0]}), 32'd3);

    // Ratios 3 and 4, then sync; then write coincident with sync
    wr_cfg(0, 3);
    wr_cfg(1, 4);
    run(7);
    sync = 1'b1; cycle(); sync = 1'b0;
    cycle();
    chk("sync_aligned", 32'({clk_out[1], clk_out[0]}), 32'd3);
    run(6);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7; sync = 1'b1;
    cycle();
    cfg_we = 1'b0; sync = 1'b0;
    chk("sync_write_applied", 32'(cfg_pending[3]), 32'd0);
    run(10);

    // Enable gating with retained configuration
    en = 4'b1010; run(3);
    en = 4'hF;    run(8);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      en      = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_div = 8'($urandom_range(0, 9));
      sync    = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    cfg_we = 1'b0; sync = 1'b0; reset = 1'b0; en = 4'hF;
    run(4);

    // Reset mid-period with a pending write
    wr_cfg(2, 9);
    wr_cfg(1, 9);
    reset = 1'b1; cycle();
    chk("reset_clears_pending", 32'(cfg_pending), 32'd0);
    chk("reset_clears_outputs", 32'({clk_out, tick}), 32'd0);
    reset = 1'b0;
    check_default_pattern("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
